lfsr_share_arb: RTL and testbench

//   Round-robin arbiter and burst sequencer sharing one XNOR LFSR (x^6+x^5+1)

---
 rtl/lfsr_share_arb.sv | 108 ++++++++++
 tb/tb_lfsr_share_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_share_arb.sv
// Two-requester round-robin arbiter sharing one XNOR LFSR (x^6+x^5+1).
// A granted requester receives a burst of len+1 words, each STEP LFSR steps apart.
module lfsr_share_arb #(
  parameter int STEP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seed_load,
  input  logic [5:0] seed,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  output logic [1:0] gnt,
  output logic [5:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state, state_n;
  logic [5:0] lfsr, lfsr_n, y_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] gnt_n;
  logic       y_valid_n, busy_n, done_n;
  logic       ptr, ptr_n, win;
  logic [5:0] lfsr_adv;

  // STEP single steps unrolled into one combinational word advance
  function automatic logic [5:0] adv(input logic [5:0] v);
    logic [5:0] r;
    r = v;
    for (int i = 0; i < STEP; i++) r = {r[4:0], r[5] ~^ r[4]};
    return r;
  endfunction

  assign lfsr_adv = adv(lfsr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lfsr    <= 6'h00;
      y       <= 6'h00;
      cnt     <= 4'h0;
      gnt     <= 2'b00;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ptr     <= 1'b0;
    end else begin
      state   <= state_n;
      lfsr    <= lfsr_n;
      y       <= y_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      y_valid <= y_valid_n;
      busy    <= busy_n;
      done    <= done_n;
      ptr     <= ptr_n;
    end
  end

  always_comb begin
    state_n   = state;
    lfsr_n    = lfsr;
    y_n       = y;
    cnt_n     = cnt;
    gnt_n     = gnt;
    y_valid_n = 1'b0;
    busy_n    = busy;
    done_n    = 1'b0;
    ptr_n     = ptr;
    win       = (req == 2'b11) ? ptr : req[1];
    case (state)
      IDLE: begin
        // the all-ones lockup state can only arrive via seed, so filter it here
        if (seed_load) begin
          lfsr_n = (seed == 6'h3F) ? 6'h00 : seed;
        end else if (req != 2'b00) begin
          state_n   = BURST;
          gnt_n     = win ? 2'b10 : 2'b01;
          cnt_n     = win ? len1 : len0;
          lfsr_n    = lfsr_adv;
          y_n       = lfsr_adv;
          y_valid_n = 1'b1;
          busy_n    = 1'b1;
          ptr_n     = ~win;
        end
      end
      BURST: begin
        if (cnt != 4'h0) begin
          lfsr_n    = lfsr_adv;
          y_n       = lfsr_adv;
          y_valid_n = 1'b1;
          cnt_n     = cnt - 4'h1;
        end else begin
          state_n = IDLE;
          gnt_n   = 2'b00;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_share_arb.sv
// Scoreboard bench: STEP=1 and STEP=3 instances share stimulus; each has its own
// expected queue drained by a negedge monitor whenever y_valid or done is seen.
module tb_lfsr_share_arb;

  typedef struct packed {
    logic       dn;
    logic [1:0] g;
    logic [5:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       seed_load = 1'b0;
  logic [5:0] seed = 6'h00;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'h0, len1 = 4'h0;
  logic [1:0] gnt0, gnt1;
  logic [5:0] y0, y1;
  logic       yv0, yv1, busy0, busy1, done0, done1;

  exp_t       q0[$], q1[$];
  logic [5:0] m[2];
  logic       mptr;
  int         n_chk = 0, n_fail = 0;
  bit         rec = 1'b0;
  logic [5:0] seen[$];

  always #5 clk = ~clk;

  lfsr_share_arb #(.STEP(1)) u0 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .req(req),
    .len0(len0), .len1(len1), .gnt(gnt0), .y(y0), .y_valid(yv0), .busy(busy0), .done(done0));

  lfsr_share_arb #(.STEP(3)) u1 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .req(req),
    .len0(len0), .len1(len1), .gnt(gnt1), .y(y1), .y_valid(yv1), .busy(busy1), .done(done1));

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [5:0] mstep(input logic [5:0] v, input int n);
    logic [5:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[4:0], r[5] ~^ r[4]};
    return r;
  endfunction

  // Monitor side: pop and compare one entry per presented output.
  task automatic mon(input int d, input logic [1:0] g, input logic yv, input logic [5:0] yy,
                     input logic bs, input logic dn);
    exp_t e;
    if (yv || dn) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk($sformatf("unexpected out u%0d", d), {4'h0, yv, dn, g, yy, bs}, 16'h0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (e.dn)
          chk($sformatf("done u%0d", d), {5'h0, yv, dn, g, yy, bs}, {5'h0, 2'b01, 2'b00, e.y, 1'b0});
        else
          chk($sformatf("word u%0d", d), {5'h0, yv, dn, g, yy, bs}, {5'h0, 2'b10, e.g, e.y, 1'b1});
        if (d == 0 && rec && yv) seen.push_back(yy);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, gnt0, yv0, y0, busy0, done0);
    mon(1, gnt1, yv1, y1, busy1, done1);
  end

  // Stimulus side: model-generated expectations for both instances.
  task automatic model_push(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                            output int n);
    logic       w;
    logic [3:0] len;
    w   = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : mptr;
    len = w ? l1 : l0;
    for (int k = 0; k <= int'(len); k++) begin
      m[0] = mstep(m[0], 1);
      m[1] = mstep(m[1], 3);
      q0.push_back('{1'b0, w ? 2'b10 : 2'b01, m[0]});
      q1.push_back('{1'b0, w ? 2'b10 : 2'b01, m[1]});
    end
    q0.push_back('{1'b1, 2'b00, m[0]});
    q1.push_back('{1'b1, 2'b00, m[1]});
    mptr = ~w;
    n = int'(len) + 1;
  endtask

  // Hand-computed word lists for both instances.
  task automatic hand(input logic [1:0] g, input int n, input logic [5:0] a[4], input logic [5:0] b[4]);
    for (int k = 0; k < n; k++) begin
      q0.push_back('{1'b0, g, a[k]});
      q1.push_back('{1'b0, g, b[k]});
    end
    q0.push_back('{1'b1, 2'b00, a[n-1]});
    q1.push_back('{1'b1, 2'b00, b[n-1]});
    m[0] = a[n-1];
    m[1] = b[n-1];
    mptr = (g == 2'b01);
  endtask

  // Called in an IDLE cycle; returns in the done cycle that follows the burst.
  task automatic drive(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                       input bit hold, input bit mid, input int n);
    req = r; len0 = l0; len1 = l1;
    @(posedge clk); #2;
    if (!hold) req = 2'b00;
    len0 = 4'hA; len1 = 4'hA;
    if (mid) begin seed_load = 1'b1; seed = 6'h2A; end
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #2;
      seed_load = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q0.delete(); q1.delete();
    m[0] = 6'h00; m[1] = 6'h00; mptr = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  initial begin
    int        n;
    logic [63:0] mask;
    int        cnt;
    bit        has3f;
    m[0] = 6'h00; m[1] = 6'h00; mptr = 1'b0;
    #12;
    chk("reset u0", {5'h0, gnt0, y0, yv0, busy0, done0}, 16'h0);
    chk("reset u1", {5'h0, gnt1, y1, yv1, busy1, done1}, 16'h0);
    @(posedge clk); #2 reset = 1'b1;

    // plain burst, hand values
    hand(2'b01, 4, '{6'h01, 6'h03, 6'h07, 6'h0F}, '{6'h07, 6'h3E, 6'h37, 6'h3C});
    drive(2'b01, 4'd3, 4'd0, 1'b0, 1'b0, 4);

    do_reset();
    hand(2'b10, 2, '{6'h01, 6'h03, 6'h00, 6'h00}, '{6'h07, 6'h3E, 6'h00, 6'h00});
    drive(2'b10, 4'd0, 4'd1, 1'b0, 1'b0, 2);

    // both requesting continuously: alternate grants
    for (int i = 0; i < 4; i++) begin
      model_push(2'b11, 4'd0, 4'd0, n);
      drive(2'b11, 4'd0, 4'd0, 1'b1, 1'b0, n);
    end
    req = 2'b00;

    // seed_load beats req in the same IDLE cycle; mid-burst seed ignored
    seed_load = 1'b1; seed = 6'h15; req = 2'b01; len0 = 4'd3;
    @(posedge clk); #2;
    seed_load = 1'b0;
    chk("seed no grant", {6'h0, gnt0, busy0, yv0, gnt1, busy1, yv1}, 16'h0);
    m[0] = 6'h15; m[1] = 6'h15;
    model_push(2'b01, 4'd3, 4'd0, n);
    drive(2'b01, 4'd3, 4'd0, 1'b0, 1'b1, n);

    // full period from lockup-filtered seed
    seed_load = 1'b1; seed = 6'h3F;
    @(posedge clk); #2;
    seed_load = 1'b0;
    m[0] = 6'h00; m[1] = 6'h00;
    rec = 1'b1;
    for (int i = 0; i < 64; i++) begin
      model_push(2'b01, 4'd0, 4'd0, n);
      drive(2'b01, 4'd0, 4'd0, 1'b0, 1'b0, n);
    end
    rec = 1'b0;
    mask = '0; has3f = 1'b0;
    for (int i = 0; i < 63 && i < seen.size(); i++) begin
      mask[seen[i]] = 1'b1;
      if (seen[i] == 6'h3F) has3f = 1'b1;
    end
    cnt = 0;
    for (int i = 0; i < 64; i++) cnt += int'(mask[i]);
    chk("period words seen", 16'(seen.size()), 16'd64);
    chk("period distinct", 16'(cnt), 16'd63);
    chk("no lockup", {15'h0, has3f}, 16'h0);
    if (seen.size() == 64) chk("period repeat", {10'h0, seen[63]}, {10'h0, seen[0]});

    // mid-burst async reset
    model_push(2'b01, 4'd15, 4'd0, n);
    req = 2'b01; len0 = 4'd15;
    @(posedge clk); #2 req = 2'b00;
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    q0.delete(); q1.delete();
    m[0] = 6'h00; m[1] = 6'h00; mptr = 1'b0;
    #1;
    chk("async rst u0", {5'h0, gnt0, y0, yv0, busy0, done0}, 16'h0);
    chk("async rst u1", {5'h0, gnt1, y1, yv1, busy1, done1}, 16'h0);
    @(posedge clk); #2 reset = 1'b1;
    hand(2'b01, 1, '{6'h01, 6'h00, 6'h00, 6'h00}, '{6'h07, 6'h00, 6'h00, 6'h00});
    drive(2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    #2;
    chk("q0 drained", 16'(q0.size()), 16'd0);
    chk("q1 drained", 16'(q1.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
